// File: rtl/onehot_enc_reg_if.sv
// Handshake bundle for onehot_enc_reg: request side (enablePin, i), result side (o, valid,
// multi, err_cnt) and consumer ready. slave is the encoder's view, master the environment's.
interface onehot_enc_reg_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 8
);
    localparam int unsigned W = $clog2(N);

    logic          enablePin;
    logic [N-1:0]  i;
    logic          ready;
    logic [W-1:0]  o;
    logic          valid;
    logic          multi;
    logic [CW-1:0] err_cnt;

    modport slave (
        input  enablePin,
        input  i,
        input  ready,
        output o,
        output valid,
        output multi,
        output err_cnt
    );

    modport master (
        output enablePin,
        output i,
        output ready,
        input  o,
        input  valid,
        input  multi,
        input  err_cnt
    );
endinterface

// File: rtl/onehot_enc_reg.sv
// Registered N-to-log2(N) priority encoder with active-low enable and valid/ready hold.
// Define ONEHOT_ENC_LSB_PRIORITY_EN to encode the lowest set bit instead of the highest.
module onehot_enc_reg #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    onehot_enc_reg_if.slave     bus
);
    localparam int unsigned W = $clog2(N);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  o_q, o_d;
    logic          multi_q, multi_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;

    logic          capture;
    logic [W-1:0]  enc_idx;
    logic          enc_multi;

    always_comb begin
        enc_idx = '0;
`ifdef ONEHOT_ENC_LSB_PRIORITY_EN
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (bus.i[k]) enc_idx = W'(k);
        end
`else
        for (int k = 0; k < int'(N); k++) begin
            if (bus.i[k]) enc_idx = W'(k);
        end
`endif
    end

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign enc_multi = (bus.i & (bus.i - N'(1))) != '0;

    // In StHold valid is 1, so valid&&ready reduces to ready.
    assign capture = !bus.enablePin && (bus.i != '0) && ((state_q == StIdle) || bus.ready);

    always_comb begin
        state_d   = state_q;
        o_d       = o_q;
        multi_d   = multi_q;
        err_cnt_d = err_cnt_q;
        if (capture) begin
            state_d = StHold;
            o_d     = enc_idx;
            multi_d = enc_multi;
            if (enc_multi && (err_cnt_q != {CW{1'b1}})) err_cnt_d = err_cnt_q + CW'(1);
        end else if ((state_q == StHold) && bus.ready) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            o_q       <= '0;
            multi_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            o_q       <= o_d;
            multi_q   <= multi_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.o       = o_q;
    assign bus.valid   = (state_q == StHold);
    assign bus.multi   = multi_q;
    assign bus.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_onehot_enc_reg.sv
// Scoreboard bench for onehot_enc_reg: expected results are queued when a capture is driven
// and popped when the DUT presents them.
module tb_onehot_enc_reg;
    localparam int unsigned N  = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned W  = $clog2(N);

    typedef struct packed {
        logic [W-1:0] o;
        logic         multi;
    } exp_t;

    logic clk;
    logic rst_n;

    onehot_enc_reg_if #(.N(N), .CW(CW)) bus ();

    onehot_enc_reg #(.N(N), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned   n_cmp;
    int unsigned   n_err;
    exp_t          exp_q[$];
    exp_t          last_exp;
    logic          model_hold;
    logic [CW-1:0] model_err;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_idx(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
`ifdef ONEHOT_ENC_LSB_PRIORITY_EN
        for (int k = 0; k < int'(N); k++) begin
            if (v[k]) begin
                r = W'(k);
                break;
            end
        end
`else
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (v[k]) begin
                r = W'(k);
                break;
            end
        end
`endif
        return r;
    endfunction

    // Drive one cycle of stimulus, advance one edge, then check the DUT against the model.
    task automatic step(input logic en, input logic [N-1:0] iv, input logic rdy, input string tag);
        logic cap;
        exp_t e;
        cap = !en && (iv != '0) && (!model_hold || rdy);
        if (cap) begin
            e.o     = ref_idx(iv);
            e.multi = ($countones(iv) > 1);
            exp_q.push_back(e);
            if (e.multi && (model_err != {CW{1'b1}})) model_err = model_err + 1'b1;
        end
        bus.enablePin = en;
        bus.i         = iv;
        bus.ready     = rdy;
        @(posedge clk);
        #1;
        model_hold = cap || (model_hold && !rdy);
        check_val({tag, ".valid"}, 32'(bus.valid), 32'(model_hold));
        if (cap) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s.queue: got empty, expected 1 entry", tag);
            end else begin
                last_exp = exp_q.pop_front();
            end
            check_val({tag, ".o"}, 32'(bus.o), 32'(last_exp.o));
            check_val({tag, ".multi"}, 32'(bus.multi), 32'(last_exp.multi));
        end else if (model_hold) begin
            check_val({tag, ".o_hold"}, 32'(bus.o), 32'(last_exp.o));
            check_val({tag, ".multi_hold"}, 32'(bus.multi), 32'(last_exp.multi));
        end
        check_val({tag, ".err_cnt"}, 32'(bus.err_cnt), 32'(model_err));
    endtask

    task automatic model_reset();
        model_hold = 1'b0;
        model_err  = '0;
        last_exp   = '0;
        exp_q.delete();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();
        rst_n         = 1'b0;
        bus.enablePin = 1'b1;
        bus.i         = '0;
        bus.ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst.valid", 32'(bus.valid), 0);
        check_val("rst.o", 32'(bus.o), 0);
        check_val("rst.multi", 32'(bus.multi), 0);
        check_val("rst.err_cnt", 32'(bus.err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All-zero request never captures.
        repeat (3) step(1'b0, 4'b0000, 1'b1, "zero");
        // Enable high blocks capture from idle.
        repeat (4) step(1'b1, 4'b1000, 1'b0, "en_idle");

        // One-hot sweep, back-to-back.
        step(1'b0, 4'b0001, 1'b1, "sweep0");
        step(1'b0, 4'b0010, 1'b1, "sweep1");
        step(1'b0, 4'b0100, 1'b1, "sweep2");
        step(1'b0, 4'b1000, 1'b1, "sweep3");

        // Backpressure: result must stay put while i moves.
        step(1'b0, 4'b0100, 1'b1, "bp_load");
        repeat (5) step(1'b0, 4'b1000, 1'b0, "bp_hold");
        step(1'b0, 4'b1000, 1'b1, "bp_release");

        // Enable high in HOLD lets the pending transfer finish without a new capture.
        step(1'b0, 4'b0010, 1'b1, "en_load");
        step(1'b1, 4'b1000, 1'b1, "en_drain");
        step(1'b1, 4'b1000, 1'b1, "en_idle2");

        // Multi-hot detection and counting.
        step(1'b0, 4'b0110, 1'b1, "multi");
`ifdef ONEHOT_ENC_LSB_PRIORITY_EN
        check_val("multi.o_abs", 32'(bus.o), 1);
`else
        check_val("multi.o_abs", 32'(bus.o), 2);
`endif
        check_val("multi.err_abs", 32'(bus.err_cnt), 1);

        repeat (300) step(1'b0, 4'b1111, 1'b1, "sat");
        check_val("sat.err_abs", 32'(bus.err_cnt), 255);

        // Async reset mid-HOLD with o=3.
        step(1'b0, 4'b1000, 1'b1, "prerst_load");
        step(1'b0, 4'b1000, 1'b0, "prerst_hold");
        check_val("prerst.o_abs", 32'(bus.o), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst.valid", 32'(bus.valid), 0);
        check_val("arst.o", 32'(bus.o), 0);
        check_val("arst.multi", 32'(bus.multi), 0);
        check_val("arst.err_cnt", 32'(bus.err_cnt), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 4'b0011, 1'b1, "post_rst");
        step(1'b1, 4'b0000, 1'b1, "post_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
